// File: rtl/atomic_exec_unit.sv
// -----------------------------------------------------------------------------
// atomic_exec_unit
//
// Atomic-memory execution unit for the MEM stage. Accepts one atomic request
// over a valid/ready handshake and executes it as a locked read-modify-write
// against the data-cache port. All RV-A arithmetic, logic, swap and signed or
// unsigned min/max operations are supported.
//
// Optional feature macro: AMO_LRSC_EN
//   defined   : LR/SC with a granule-based reservation, timeout counter and
//               snoop invalidation.
//   undefined : LR (9) and SC (10) behave as reserved ops, snoop inputs are
//               ignored and no reservation logic is built.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready = unit idle)
//   req_op/addr/operand       op code, target address, rs2 value
//   rsp_valid/rsp_data        one-cycle completion pulse with rd result
//   mem_read/mem_write        memory strobes, held until mem_resp
//   mem_addr/mem_wdata        registered address and store data
//   mem_rdata/mem_resp        load data and memory handshake
//   lock/locked_address       bus lock and locked address (AMO only)
//   snoop_valid/snoop_addr    write by another agent
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; SC success is decided here
// LOAD  | mem_read held until mem_resp; loaded word captured
// CALC  | AMO result computed from loaded word and operand
// STORE | mem_write held until mem_resp
// RESP  | rsp_valid pulse with result
// -----------------------------------------------------------------------------
module atomic_exec_unit #(
  parameter int XLEN          = 32,
  parameter int RSV_GRAN_LOG2 = 2,
  parameter int RSV_TIMEOUT   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_operand,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_resp,
  output logic            lock,
  output logic [XLEN-1:0] locked_address,
  input  logic            snoop_valid,
  input  logic [XLEN-1:0] snoop_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_STORE,
    S_RESP
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4;
  localparam logic [3:0] OP_MIN  = 4'd5;
  localparam logic [3:0] OP_MAX  = 4'd6;
  localparam logic [3:0] OP_MINU = 4'd7;
  localparam logic [3:0] OP_MAXU = 4'd8;
  localparam logic [3:0] OP_LR   = 4'd9;
  localparam logic [3:0] OP_SC   = 4'd10;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  // Holds the loaded word for AMO/LR, or the SC status / reserved-op zero.
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_amo_q;
  logic              accept;
  logic [XLEN-1:0]   amo_new;
  logic              sc_ok;

  assign accept   = req_valid && (state_q == S_IDLE);
  assign is_amo_q = (op_q <= OP_MAXU);

  // ---------------------------------------------------------------------------
  // AMO combine: result_q holds the loaded word while in CALC.
  // ---------------------------------------------------------------------------
  always_comb begin
    amo_new = operand_q;
    case (op_q)
      OP_ADD:  amo_new = result_q + operand_q;
      OP_AND:  amo_new = result_q & operand_q;
      OP_OR:   amo_new = result_q | operand_q;
      OP_XOR:  amo_new = result_q ^ operand_q;
      OP_SWAP: amo_new = operand_q;
      OP_MIN:  amo_new = ($signed(result_q) < $signed(operand_q)) ? result_q : operand_q;
      OP_MAX:  amo_new = ($signed(result_q) > $signed(operand_q)) ? result_q : operand_q;
      OP_MINU: amo_new = (result_q < operand_q) ? result_q : operand_q;
      OP_MAXU: amo_new = (result_q > operand_q) ? result_q : operand_q;
      default: amo_new = operand_q;
    endcase
  end

`ifdef AMO_LRSC_EN
  // ---------------------------------------------------------------------------
  // Reservation: granule index, validity, age counter.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(RSV_TIMEOUT + 1);

  logic              rsv_valid_q, rsv_valid_d;
  logic [XLEN-1:0]   rsv_gran_q, rsv_gran_d;
  logic [CNT_W-1:0]  rsv_cnt_q, rsv_cnt_d;
  // Set when a snoop hits the LR's own granule while the LR is still loading.
  logic              lr_snooped_q, lr_snooped_d;

  logic [XLEN-1:0]   req_gran, addr_gran, snoop_gran;
  logic              snoop_rsv_hit;
  logic              snoop_lr_hit;
  logic              lr_done;

  assign req_gran      = req_addr >> RSV_GRAN_LOG2;
  assign addr_gran     = addr_q >> RSV_GRAN_LOG2;
  assign snoop_gran    = snoop_addr >> RSV_GRAN_LOG2;
  assign snoop_rsv_hit = snoop_valid && rsv_valid_q && (snoop_gran == rsv_gran_q);
  assign snoop_lr_hit  = snoop_valid && (snoop_gran == addr_gran);
  assign lr_done       = (state_q == S_LOAD) && (op_q == OP_LR) && mem_resp;
  assign sc_ok         = rsv_valid_q && (req_gran == rsv_gran_q) && !snoop_rsv_hit;

  always_comb begin
    rsv_valid_d  = rsv_valid_q;
    rsv_gran_d   = rsv_gran_q;
    rsv_cnt_d    = rsv_cnt_q;
    lr_snooped_d = lr_snooped_q;

    if (accept) begin
      lr_snooped_d = 1'b0;
    end else if ((state_q == S_LOAD) && snoop_lr_hit) begin
      lr_snooped_d = 1'b1;
    end

    if (rsv_valid_q) begin
      if (rsv_cnt_q != CNT_W'(RSV_TIMEOUT)) begin
        rsv_cnt_d = rsv_cnt_q + 1'b1;
      end
      // Counter reaches RSV_TIMEOUT on this edge: reservation expires.
      if (rsv_cnt_q >= CNT_W'(RSV_TIMEOUT - 1)) begin
        rsv_valid_d = 1'b0;
      end
      if (snoop_rsv_hit) begin
        rsv_valid_d = 1'b0;
      end
      if ((state_q == S_STORE) && is_amo_q && (addr_gran == rsv_gran_q)) begin
        rsv_valid_d = 1'b0;
      end
    end

    if (accept && (req_op == OP_SC)) begin
      rsv_valid_d = 1'b0;
    end

    if (lr_done) begin
      rsv_valid_d = !(lr_snooped_q || snoop_lr_hit);
      rsv_gran_d  = addr_gran;
      rsv_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsv_valid_q  <= 1'b0;
      rsv_gran_q   <= '0;
      rsv_cnt_q    <= '0;
      lr_snooped_q <= 1'b0;
    end else begin
      rsv_valid_q  <= rsv_valid_d;
      rsv_gran_q   <= rsv_gran_d;
      rsv_cnt_q    <= rsv_cnt_d;
      lr_snooped_q <= lr_snooped_d;
    end
  end
`else
  logic unused_lrsc;
  assign sc_ok       = 1'b0;
  assign unused_lrsc = ^{snoop_valid, snoop_addr, sc_ok}
                       ^ (RSV_GRAN_LOG2 != RSV_TIMEOUT);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    wdata_d   = wdata_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_d    = req_addr;
          operand_d = req_operand;
          if (req_op <= OP_MAXU) begin
            state_d = S_LOAD;
          end
`ifdef AMO_LRSC_EN
          else if (req_op == OP_LR) begin
            state_d = S_LOAD;
          end else if (req_op == OP_SC) begin
            if (sc_ok) begin
              state_d  = S_STORE;
              wdata_d  = req_operand;
              result_d = '0;
            end else begin
              state_d  = S_RESP;
              result_d = XLEN'(1);
            end
          end
`endif
          else begin
            state_d  = S_RESP;
            result_d = '0;
          end
        end
      end
      S_LOAD: begin
        if (mem_resp) begin
          result_d = mem_rdata;
          state_d  = (op_q == OP_LR) ? S_RESP : S_CALC;
        end
      end
      S_CALC: begin
        wdata_d = amo_new;
        state_d = S_STORE;
      end
      S_STORE: begin
        if (mem_resp) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      wdata_q   <= wdata_d;
      result_q  <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so reset drops them at once.
  // ---------------------------------------------------------------------------
  assign req_ready      = (state_q == S_IDLE);
  assign mem_read       = (state_q == S_LOAD);
  assign mem_write      = (state_q == S_STORE);
  assign mem_addr       = (mem_read || mem_write) ? addr_q : '0;
  assign mem_wdata      = mem_write ? wdata_q : '0;
  assign lock           = is_amo_q && ((state_q == S_LOAD) || (state_q == S_CALC) ||
                                       (state_q == S_STORE));
  assign locked_address = lock ? addr_q : '0;
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_data       = rsp_valid ? result_q : '0;

endmodule

// File: tb/tb_atomic_exec_unit.sv
module tb_atomic_exec_unit;
  localparam int XLEN = 32;
  localparam int G    = 2;
  localparam int TO   = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      req_op = '0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_operand = '0;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            mem_read, mem_write;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            mem_resp = 1'b0;
  logic            lock;
  logic [XLEN-1:0] locked_address;
  logic            snoop_valid = 1'b0;
  logic [XLEN-1:0] snoop_addr = '0;

  atomic_exec_unit #(.XLEN(XLEN), .RSV_GRAN_LOG2(G), .RSV_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_operand(req_operand),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .lock(lock), .locked_address(locked_address),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef AMO_LRSC_EN
  localparam bit LRSC = 1'b1;
`else
  localparam bit LRSC = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model state ----------------
  logic [31:0] mem [logic [31:0]];
  bit          rsv_v = 1'b0;
  logic [31:0] rsv_g = '0;
  int          lr_cyc = 0;

  typedef struct { bit rd; bit wr; bit lk; bit rv; bit resp; } ent_t;
  ent_t        sched[$];
  logic [31:0] e_rsp, e_wdata, e_old;
  logic [31:0] got_rsp, got_wd;

  function automatic ent_t mk(bit rd, bit wr, bit lk, bit rv, bit resp);
    ent_t e;
    e.rd = rd; e.wr = wr; e.lk = lk; e.rv = rv; e.resp = resp;
    return e;
  endfunction

  function automatic logic [31:0] gran(logic [31:0] a);
    return a >> G;
  endfunction

  function automatic logic [31:0] get_mem(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  function automatic logic [31:0] amo_f(int op, logic [31:0] a, logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a & b;
      2: return a | b;
      3: return a ^ b;
      4: return b;
      5: return ($signed(a) < $signed(b)) ? a : b;
      6: return ($signed(a) > $signed(b)) ? a : b;
      7: return (a < b) ? a : b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  task automatic expire(input int c);
    if (rsv_v && (c - lr_cyc) >= TO) rsv_v = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    req_valid   = 1'b0;
    snoop_valid = 1'b0;
    mem_resp    = 1'b0;
    mem_rdata   = $urandom;
  endtask

  task automatic chk_idle();
    chk("idle_ready", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_rsp_data", rsp_data, 0);
    chk("idle_strobes", {mem_read, mem_write}, 0);
    chk("idle_lock", lock, 0);
  endtask

  // Idle cycles; optional one-cycle snoop on the first of them.
  task automatic idle(input int n, input bit snp, input logic [31:0] sa);
    for (int i = 0; i < n; i++) begin
      step();
      chk_idle();
      if (i == 0 && snp) begin
        snoop_valid = 1'b1;
        snoop_addr  = sa;
        expire(cyc);
        if (LRSC && rsv_v && gran(sa) == rsv_g) rsv_v = 1'b0;
      end
    end
  endtask

  // Model one request, build its cycle schedule, drive and check it.
  // snp_s: -1 none, 0 snoop in accept cycle, 1 snoop in the first cycle after.
  task automatic do_op(input int op, input logic [31:0] addr, input logic [31:0] operand,
                       input int rw, input int ww, input int snp_s, input logic [31:0] snp_a);
    int c0;
    bit ok;
    step();
    c0 = cyc;
    chk("accept_ready", req_ready, 1);
    chk("accept_rsp_valid", rsp_valid, 0);
    req_valid   = 1'b1;
    req_op      = op[3:0];
    req_addr    = addr;
    req_operand = operand;
    if (snp_s == 0) begin
      snoop_valid = 1'b1;
      snoop_addr  = snp_a;
    end

    sched.delete();
    e_wdata = '0;
    e_old   = '0;
    expire(c0);
    if (LRSC && snp_s == 0 && rsv_v && gran(snp_a) == rsv_g) rsv_v = 1'b0;
    if (op <= 8) begin
      e_old   = get_mem(addr);
      e_wdata = amo_f(op, e_old, operand);
      e_rsp   = e_old;
      for (int i = 0; i <= rw; i++) sched.push_back(mk(1, 0, 1, 0, i == rw));
      sched.push_back(mk(0, 0, 1, 0, 0));
      for (int i = 0; i <= ww; i++) sched.push_back(mk(0, 1, 1, 0, i == ww));
      sched.push_back(mk(0, 0, 0, 1, 0));
      mem[addr] = e_wdata;
      if (LRSC && snp_s == 1 && rsv_v && gran(snp_a) == rsv_g) rsv_v = 1'b0;
      if (rsv_v && gran(addr) == rsv_g) rsv_v = 1'b0;
    end else if (LRSC && op == 9) begin
      e_old = get_mem(addr);
      e_rsp = e_old;
      for (int i = 0; i <= rw; i++) sched.push_back(mk(1, 0, 0, 0, i == rw));
      sched.push_back(mk(0, 0, 0, 1, 0));
      rsv_v  = !(snp_s == 1 && gran(snp_a) == gran(addr));
      rsv_g  = gran(addr);
      lr_cyc = c0 + 2 + rw;
    end else if (LRSC && op == 10) begin
      ok    = rsv_v && gran(addr) == rsv_g;
      rsv_v = 1'b0;
      if (ok) begin
        e_wdata = operand;
        e_rsp   = 32'd0;
        for (int i = 0; i <= ww; i++) sched.push_back(mk(0, 1, 0, 0, i == ww));
        mem[addr] = operand;
      end else begin
        e_rsp = 32'd1;
      end
      sched.push_back(mk(0, 0, 0, 1, 0));
    end else begin
      e_rsp = 32'd0;
      sched.push_back(mk(0, 0, 0, 1, 0));
      if (LRSC && snp_s == 1 && rsv_v && gran(snp_a) == rsv_g) rsv_v = 1'b0;
    end

    got_rsp = 32'hDEAD_BEEF;
    got_wd  = 32'hDEAD_BEEF;
    for (int i = 0; i < sched.size(); i++) begin
      step();
      if (i == 0 && snp_s == 1) begin
        snoop_valid = 1'b1;
        snoop_addr  = snp_a;
      end
      chk("busy_ready", req_ready, 0);
      chk("mem_read", mem_read, sched[i].rd);
      chk("mem_write", mem_write, sched[i].wr);
      chk("lock", lock, sched[i].lk);
      chk("locked_address", locked_address, sched[i].lk ? addr : 32'd0);
      if (sched[i].rd || sched[i].wr) chk("mem_addr", mem_addr, addr);
      if (sched[i].wr) begin
        chk("mem_wdata", mem_wdata, e_wdata);
        got_wd = mem_wdata;
      end
      chk("rsp_valid", rsp_valid, sched[i].rv);
      chk("rsp_data", rsp_data, sched[i].rv ? e_rsp : 32'd0);
      if (sched[i].rv) got_rsp = rsp_data;
      mem_resp = sched[i].resp;
      if (sched[i].rd && sched[i].resp) mem_rdata = e_old;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, rw, ww, ss, gap;
    logic [31:0] a, opd, sa;

    // Reset state
    step();
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_lock", lock, 0);
    chk("rst_locked_address", locked_address, 0);
    rst = 1'b0;
    idle(2, 0, 0);

    // AMOADD: 5 + 0xFFFFFFFF
    mem[32'h40] = 32'h0000_0005;
    do_op(0, 32'h40, 32'hFFFF_FFFF, 0, 0, -1, 0);
    chk("amoadd_rsp_lit", got_rsp, 32'h0000_0005);
    chk("amoadd_wdata_lit", got_wd, 32'h0000_0004);

    // AMOMIN vs AMOMINU with 0x80000000 in memory, operand 1
    mem[32'h50] = 32'h8000_0000;
    mem[32'h54] = 32'h8000_0000;
    do_op(5, 32'h50, 32'h1, 1, 2, -1, 0);
    chk("amomin_wdata_lit", got_wd, 32'h8000_0000);
    do_op(7, 32'h54, 32'h1, 0, 1, -1, 0);
    chk("amominu_wdata_lit", got_wd, 32'h0000_0001);
    do_op(6, 32'h54, 32'hFFFF_FFFF, 0, 0, -1, 0);
    chk("amomax_wdata_lit", got_wd, 32'h0000_0001);

    // LR/SC sequences
    do_op(9, 32'h60, 0, 0, 0, -1, 0);
    do_op(10, 32'h60, 32'hAAAA_5555, 0, 0, -1, 0);
    chk("sc1_rsp_lit", got_rsp, LRSC ? 32'd0 : 32'd0);
    do_op(10, 32'h60, 32'h1234_5678, 0, 0, -1, 0);
    chk("sc2_rsp_lit", got_rsp, LRSC ? 32'd1 : 32'd0);

    do_op(9, 32'h70, 0, 1, 0, -1, 0);
    idle(1, 1, 32'h72);
    do_op(10, 32'h70, 32'h1, 0, 0, -1, 0);
    chk("sc_snoop_same_lit", got_rsp, LRSC ? 32'd1 : 32'd0);
    do_op(9, 32'h70, 0, 0, 0, -1, 0);
    idle(1, 1, 32'h74);
    do_op(10, 32'h70, 32'h2, 0, 1, -1, 0);
    chk("sc_snoop_other_lit", got_rsp, 32'd0);

    // Timeout boundary
    do_op(9, 32'h80, 0, 0, 0, -1, 0);
    idle(TO - 2, 0, 0);
    do_op(10, 32'h80, 32'h3, 0, 0, -1, 0);
    chk("sc_before_timeout_lit", got_rsp, 32'd0);
    do_op(9, 32'h80, 0, 0, 0, -1, 0);
    idle(TO - 1, 0, 0);
    do_op(10, 32'h80, 32'h4, 0, 0, -1, 0);
    chk("sc_at_timeout_lit", got_rsp, LRSC ? 32'd1 : 32'd0);

    // Snoop on the LR's granule while it is loading
    do_op(9, 32'h90, 0, 1, 0, 1, 32'h91);
    do_op(10, 32'h90, 32'h5, 0, 0, -1, 0);
    chk("sc_lr_snooped_lit", got_rsp, LRSC ? 32'd1 : 32'd0);

    // Reserved op
    do_op(13, 32'h44, 32'h9, 0, 0, -1, 0);
    chk("reserved_rsp_lit", got_rsp, 32'd0);

    // Reset during an AMO STORE with mem_resp low
    do_op(9, 32'h200, 0, 0, 0, -1, 0);
    step();
    chk("rs_ready", req_ready, 1);
    req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h300; req_operand = 32'h11;
    step();
    chk("rs_load", mem_read, 1);
    mem_resp = 1'b1; mem_rdata = get_mem(32'h300);
    step();
    chk("rs_calc_lock", lock, 1);
    step();
    chk("rs_store", mem_write, 1);
    #1 rst = 1'b1;
    #1;
    chk("rs_mem_write", mem_write, 0);
    chk("rs_mem_read", mem_read, 0);
    chk("rs_lock", lock, 0);
    chk("rs_locked_address", locked_address, 0);
    chk("rs_rsp_valid", rsp_valid, 0);
    chk("rs_ready_after", req_ready, 1);
    step();
    step();
    rst   = 1'b0;
    rsv_v = 1'b0;
    do_op(10, 32'h200, 32'h77, 0, 0, -1, 0);
    chk("rs_sc_fails_lit", got_rsp, LRSC ? 32'd1 : 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 19);
      if (op >= 16) op = (op < 18) ? 9 : 10;
      a = 32'h100 + 32'(4 * $urandom_range(0, 3));
      if (op == 9 || op == 10) a = a + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: opd = 32'h0;
        1: opd = 32'h1;
        2: opd = 32'hFFFF_FFFF;
        3: opd = 32'h8000_0000;
        4: opd = 32'h7FFF_FFFF;
        default: opd = $urandom;
      endcase
      rw = $urandom_range(0, 2);
      ww = $urandom_range(0, 2);
      ss = int'($urandom_range(0, 3)) - 2;
      sa = 32'h100 + 32'($urandom_range(0, 15));
      do_op(op, a, opd, rw, ww, ss, sa);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap, $urandom_range(0, 2) == 0, 32'h100 + 32'($urandom_range(0, 15)));
    end

    idle(2, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
